// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the weight ROM row by row, drives one shared neuron
// through its start/done handshake, and packs ReLU-saturated results into out_data.
module layer_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 2,
    parameter int NEURONS = 4,
    parameter int SHIFT   = 0,
    parameter int TIMEOUT = 64,
    localparam int AW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int TW = $clog2(TIMEOUT + 1),
    localparam int RW = 2 * WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH*SIZE-1:0]      inputs,
    output logic [AW-1:0]              w_addr,
    input  logic [WIDTH*SIZE-1:0]      w_data,
    output logic                       n_start,
    output logic [WIDTH*SIZE-1:0]      n_weights,
    output logic [WIDTH*SIZE-1:0]      n_inputs,
    input  logic [RW-1:0]              n_result,
    input  logic                       n_valid,
    input  logic                       n_done,
    output logic [WIDTH*NEURONS-1:0]   out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_STORE, S_DONE
    } state_t;

    localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (WIDTH - 1)) - 1);
    localparam logic [AW-1:0]        K_LAST  = AW'(NEURONS - 1);
    localparam logic [TW-1:0]        T_LAST  = TW'(TIMEOUT - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [AW-1:0]              r_k;
    logic [AW-1:0]              r_w_addr;
    logic [WIDTH*SIZE-1:0]      r_n_weights;
    logic [WIDTH*SIZE-1:0]      r_n_inputs;
    logic [WIDTH*NEURONS-1:0]   r_out_data;
    logic                       r_error;
    logic [TW-1:0]              r_cnt;
    logic [RW-1:0]              r_result;
    logic                       w_expired;
    logic signed [RW-1:0]       w_shifted;
    logic [WIDTH-1:0]           w_slot;

    // The final WAIT cycle of the budget still honours a same-cycle n_done.
    assign w_expired = !n_done && (r_cnt == T_LAST);
    assign w_shifted = $signed(r_result) >>> SHIFT;

    always_comb begin
        w_slot = w_shifted[WIDTH-1:0];
        if (w_shifted[RW-1]) begin
            w_slot = '0;
        end else if (w_shifted > SAT_MAX) begin
            w_slot = SAT_MAX[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (n_done || w_expired) w_state_next = S_STORE;
            S_STORE: w_state_next = (r_k == K_LAST) ? S_DONE : S_FETCH;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_k         <= '0;
            r_w_addr    <= '0;
            r_n_weights <= '0;
            r_n_inputs  <= '0;
            r_out_data  <= '0;
            r_error     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n_inputs <= inputs;
                        r_out_data <= '0;
                        r_error    <= 1'b0;
                        r_k        <= '0;
                        r_w_addr   <= '0;
                    end
                end
                S_LOAD:  r_n_weights <= w_data;
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    if (n_done) begin
                        r_result <= n_valid ? n_result : '0;
                        if (!n_valid) r_error <= 1'b1;
                    end else if (w_expired) begin
                        r_result <= '0;
                        r_error  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STORE: begin
                    r_out_data[r_k*WIDTH +: WIDTH] <= w_slot;
                    // Address is set on entry to FETCH so the ROM row lands in LOAD.
                    if (r_k != K_LAST) begin
                        r_k      <= r_k + 1'b1;
                        r_w_addr <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_addr    = r_w_addr;
    assign n_start   = (r_state == S_ISSUE);
    assign n_weights = r_n_weights;
    assign n_inputs  = r_n_inputs;
    assign out_data  = r_out_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign error     = r_error;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (SHIFT 0 and 2) share stimulus and a
// ROM; each has its own mock neuron, checked every cycle against a pass-level model.
module tb_layer_sequencer;

    localparam int N  = 2;
    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] inputs;
    logic [15:0] rom [2];
    int          m_delay;
    bit          m_valid;

    logic [0:0]  w_addr_a    [2];
    logic        n_start_a   [2];
    logic [15:0] n_weights_a [2];
    logic [15:0] n_inputs_a  [2];
    logic [15:0] out_a       [2];
    logic        busy_a      [2];
    logic        done_a      [2];
    logic        err_a       [2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    bit          have_pass;
    int          t_acc;
    int          m_w;
    bit          m_fail;
    logic [15:0] cap_in;
    logic [15:0] cap_rom [2];
    logic [15:0] exp_out [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] rd;
        logic [16:0] nres;
        logic        nd;
        logic        pend;
        int          mcnt;
        int          dot;

        always @(posedge clk) rd <= rom[w_addr_a[g]];

        always_comb begin
            dot = 0;
            for (int i = 0; i < 2; i++)
                dot += int'($signed(n_weights_a[g][i*8 +: 8])) * int'($signed(n_inputs_a[g][i*8 +: 8]));
        end
        assign nres = dot[16:0];
        assign nd   = pend && (m_delay != 0) && (mcnt == m_delay);

        always @(posedge clk or negedge reset) begin
            if (!reset) begin
                pend <= 1'b0;
                mcnt <= 0;
            end else if (n_start_a[g]) begin
                pend <= 1'b1;
                mcnt <= 1;
            end else if (pend) begin
                mcnt <= mcnt + 1;
                if (nd) pend <= 1'b0;
            end
        end

        layer_sequencer #(.WIDTH(8), .SIZE(2), .NEURONS(N), .SHIFT(g * 2), .TIMEOUT(TO)) u_dut (
            .clk(clk), .reset(reset), .start(start), .inputs(inputs),
            .w_addr(w_addr_a[g]), .w_data(rd),
            .n_start(n_start_a[g]), .n_weights(n_weights_a[g]), .n_inputs(n_inputs_a[g]),
            .n_result(nres), .n_valid(nd && m_valid), .n_done(nd),
            .out_data(out_a[g]), .busy(busy_a[g]), .done(done_a[g]), .error(err_a[g])
        );
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h want %0h", nm, g, cyc, act, exp);
        end
    endtask

    function automatic int dotf(input logic [15:0] w, input logic [15:0] x);
        int s = 0;
        for (int i = 0; i < 2; i++)
            s += int'($signed(w[i*8 +: 8])) * int'($signed(x[i*8 +: 8]));
        return s;
    endfunction

    function automatic logic [7:0] actf(input int d, input int sh);
        int r;
        r = d >>> sh;
        if (r < 0) return 8'd0;
        if (r > 127) return 8'd127;
        return r[7:0];
    endfunction

    // Per-cycle expectations derived from pass offset o (cycles since acceptance edge).
    task automatic check_cycle(input int g);
        int o, len, j, p, comp;
        logic [15:0] eo;
        o   = cyc - t_acc;
        len = N * (4 + m_w);
        if (have_pass && o >= 1 && o <= len + 1) begin
            j    = (o - 1) / (4 + m_w);
            p    = (o - 1) % (4 + m_w);
            comp = (o - 1) / (4 + m_w);
            if (comp > N) comp = N;
            eo = '0;
            for (int k = 0; k < N; k++)
                if (k < comp) eo[k*8 +: 8] = exp_out[g][k*8 +: 8];
            chk("busy", g, busy_a[g], 1);
            chk("done", g, done_a[g], (o == len + 1));
            chk("n_start", g, n_start_a[g], (o <= len && p == 2));
            if (o <= len && p == 0) chk("w_addr", g, w_addr_a[g], j);
            if (o <= len && p >= 2 && p <= 2 + m_w) begin
                chk("n_weights", g, n_weights_a[g], cap_rom[j]);
                chk("n_inputs", g, n_inputs_a[g], cap_in);
            end
            chk("out_data", g, out_a[g], eo);
            chk("error", g, err_a[g], (m_fail && o >= 4 + m_w));
        end else if (have_pass && o > len + 1) begin
            chk("idle_busy", g, busy_a[g], 0);
            chk("idle_done", g, done_a[g], 0);
            chk("idle_n_start", g, n_start_a[g], 0);
            chk("idle_out", g, out_a[g], exp_out[g]);
            chk("idle_error", g, err_a[g], m_fail);
        end else begin
            chk("rst_busy", g, busy_a[g], 0);
            chk("rst_done", g, done_a[g], 0);
            chk("rst_n_start", g, n_start_a[g], 0);
            chk("rst_out", g, out_a[g], 0);
            chk("rst_error", g, err_a[g], 0);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) check_cycle(g);
    end

    task automatic start_pass(input logic [15:0] in_v, input logic [15:0] r0, input logic [15:0] r1,
                              input int d, input bit v);
        @(negedge clk);
        #1;
        rom[0]  = r0;
        rom[1]  = r1;
        inputs  = in_v;
        m_delay = d;
        m_valid = v;
        start   = 1'b1;
        t_acc   = cyc;
        m_w     = (d == 0) ? TO : d;
        m_fail  = (d == 0) || !v;
        cap_in  = in_v;
        cap_rom[0] = r0;
        cap_rom[1] = r1;
        for (int g = 0; g < 2; g++)
            exp_out[g] = m_fail ? 16'h0000 : {actf(dotf(r1, in_v), g * 2), actf(dotf(r0, in_v), g * 2)};
        have_pass = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_off, input logic [15:0] e0, input logic [15:0] e1, input bit e_err);
        int got = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a[0]) begin
                got = cyc - t_acc;
                break;
            end
        end
        chk("done_cycle", 0, got, exp_off);
        if (got >= 0) begin
            chk("pin_out", 0, out_a[0], e0);
            chk("pin_out", 1, out_a[1], e1);
            chk("pin_error", 0, err_a[0], e_err);
            chk("pin_error", 1, err_a[1], e_err);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        inputs = '0;
        m_delay = 5;
        m_valid = 1'b1;
        rom[0] = '0;
        rom[1] = '0;
        have_pass = 1'b0;
        t_acc = 0;
        m_w = 1;
        m_fail = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset_busy", g, busy_a[g], 0);
            chk("reset_done", g, done_a[g], 0);
            chk("reset_n_start", g, n_start_a[g], 0);
            chk("reset_w_addr", g, w_addr_a[g], 0);
            chk("reset_out", g, out_a[g], 0);
            chk("reset_error", g, err_a[g], 0);
        end
        #1 reset = 1'b1;

        // inputs {2,2}; rows {4,3}=14 and {-2,-1}=-6
        start_pass(16'h0202, 16'h0304, 16'hFFFE, 5, 1'b1);
        wait_done(19, 16'h000E, 16'h0003, 1'b0);
        // inputs {1,1}; rows {100,100}=200 and {-1,-2}=-3
        start_pass(16'h0101, 16'h6464, 16'hFEFF, 1, 1'b1);
        wait_done(11, 16'h007F, 16'h0032, 1'b0);
        // neuron never answers: both slots time out
        start_pass(16'h0202, 16'h0304, 16'hFFFE, 0, 1'b1);
        wait_done(41, 16'h0000, 16'h0000, 1'b1);
        // n_done on the expiry cycle is a normal completion
        start_pass(16'h0202, 16'h0304, 16'hFFFE, TO, 1'b1);
        wait_done(41, 16'h000E, 16'h0003, 1'b0);
        // done without valid
        start_pass(16'h0202, 16'h0304, 16'hFFFE, 3, 1'b0);
        wait_done(15, 16'h0000, 16'h0000, 1'b1);
        // start pulsed during WAIT with changed inputs must be ignored
        start_pass(16'h0202, 16'h0304, 16'hFFFE, 5, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        start = 1'b1;
        inputs = 16'h7F7F;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(19, 16'h000E, 16'h0003, 1'b0);
        // reset during the second neuron's WAIT, after error is already set
        start_pass(16'h0202, 16'h0304, 16'hFFFE, 3, 1'b0);
        repeat (11) @(negedge clk);
        #1;
        reset = 1'b0;
        have_pass = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("midrst_n_start", g, n_start_a[g], 0);
            chk("midrst_busy", g, busy_a[g], 0);
            chk("midrst_out", g, out_a[g], 0);
            chk("midrst_error", g, err_a[g], 0);
        end
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        start_pass(16'h0101, 16'h6464, 16'hFEFF, 2, 1'b1);
        wait_done(13, 16'h007F, 16'h0032, 1'b0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
